// File: rtl/ram_responder.sv
// ram_responder: fixed-latency word RAM behind a FREE/BUSY/ACCESS/ERROR handshake.
// Define RAM_RESPONDER_STATS_EN to add rd_count/wr_count/err_count outputs.
module ram_responder #(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
`ifdef RAM_RESPONDER_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [31:0] err_count
`endif
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [3:0] LAT_C = 4'(LAT);

   // state codes double as the ramstate encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_ACC  = 2'b10,
      S_ERR  = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic            op_q, op_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [31:0]     data_q, data_d;
   logic [31:0]     load_q, load_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     mem [DEPTH];
   logic [IW-1:0]   idx;
   logic            legal, one_req, changed, commit;

   assign idx     = ramaddr[IW+1:2];
   assign legal   = (ramaddr[1:0] == 2'b00) && ((ramaddr >> (IW + 2)) == 32'd0);
   assign one_req = ramREN ^ ramWEN;
   assign changed = (ramWEN != op_q) || (idx != idx_q) || (ramWEN && ramstore != data_q);
   assign commit  = (state_q == S_ACC) && op_q && ramWEN && legal && (idx == idx_q);
   assign ramstate = state_q;
   assign ramload  = load_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      load_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (ramREN || ramWEN) begin
               if (one_req && legal) begin
                  state_d = S_WAIT;
                  op_d    = ramWEN;
                  idx_d   = idx;
                  data_d  = ramstore;
                  cnt_d   = LAT_C;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_WAIT: begin
            if (!ramREN && !ramWEN) begin
               state_d = S_IDLE;
            end else if (!one_req || !legal) begin
               state_d = S_ERR;
            end else if (changed) begin
               op_d   = ramWEN;
               idx_d  = idx;
               data_d = ramstore;
               cnt_d  = LAT_C;
            end else if (cnt_q == 4'd1) begin
               state_d = S_ACC;
               cnt_d   = '0;
               load_d  = op_q ? 32'd0 : mem[idx_q];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         load_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
      end
   end

   // memory survives reset; a reset in ACC suppresses the commit
   always_ff @(posedge CLK) begin
      if (nRST && commit) mem[idx_q] <= data_q;
   end

`ifdef RAM_RESPONDER_STATS_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else begin
         if (state_q == S_ACC && !op_q) rd_count <= rd_count + 32'd1;
         if (commit) wr_count <= wr_count + 32'd1;
         if (state_d == S_ERR) err_count <= err_count + 32'd1;
      end
   end
`endif
endmodule
